// File: rtl/avg_pkg.sv
// Shared sizing helpers and default parameters for the moving_average_mc filter.
// Contents: clog2, sum/pointer/fill width helpers, default NCH/DW/DEPTH.
package avg_pkg;

  localparam int unsigned NCH_DEF   = 4;
  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned DEPTH_DEF = 6;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Running sum of DEPTH samples of DW bits never overflows this width.
  function automatic int unsigned sum_w(input int unsigned dw, input int unsigned depth);
    return dw + clog2(depth);
  endfunction

  // Ring write pointer, 0..DEPTH-1 (DEPTH >= 2 so at least 1 bit).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return clog2(depth);
  endfunction

  // Fill counter, 0..DEPTH inclusive.
  function automatic int unsigned fill_w(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/avg_chan.sv
// One boxcar channel: en edge-sync chain, DEPTH-deep ring, running sum,
// fill counter, constant divider and registered average output.
// Optional build macro AVG_ROUND_EN: round half-up instead of truncating.
// Ports:
//   clk, rst   clock, async active-high reset
//   clr        synchronous clear of window, sum, pointer, fill, full
//   data       sample lane (sampled directly on the capture edge)
//   en         sample strobe level; rising edge triggers one capture
//   en_d       en delayed one clk
//   avg        registered average, vld pulses one cycle when it updates
//   full       window holds DEPTH samples
module avg_chan
  import avg_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] data,
  input  logic          en,
  output logic          en_d,
  output logic [DW-1:0] avg,
  output logic          vld,
  output logic          full
);

  localparam int unsigned SW = sum_w(DW, DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned FW = fill_w(DEPTH);
  localparam int unsigned RW = SW + 1;

  logic [2:0]    sync_q;
  logic          rise_c;
  logic [DW-1:0] ring_q [DEPTH];
  logic [SW-1:0] sum_q;
  logic [PW-1:0] wp_q;
  logic [FW-1:0] fill_q;
  logic          pend_q;
  logic [DW-1:0] avg_c;

  assign rise_c = sync_q[1] & ~sync_q[2];

  // Quotient always fits DW bits since sum <= DEPTH * (2^DW - 1).
`ifdef AVG_ROUND_EN
  assign avg_c = DW'((RW'(sum_q) + RW'(DEPTH / 2)) / RW'(DEPTH));
`else
  assign avg_c = DW'(sum_q / SW'(DEPTH));
`endif

  // Strobe sync chain and en delay; unaffected by clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      en_d   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], en};
      en_d   <= en;
    end
  end

  // Window capture and output stage; clr overrides both capture and update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) ring_q[i] <= '0;
      sum_q  <= '0;
      wp_q   <= '0;
      fill_q <= '0;
      full   <= 1'b0;
      pend_q <= 1'b0;
      vld    <= 1'b0;
      avg    <= '0;
    end else if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) ring_q[i] <= '0;
      sum_q  <= '0;
      wp_q   <= '0;
      fill_q <= '0;
      full   <= 1'b0;
      pend_q <= 1'b0;
      vld    <= 1'b0;
    end else begin
      pend_q <= rise_c;
      vld    <= pend_q;
      if (pend_q) avg <= avg_c;
      if (rise_c) begin
        // Evicted slot is part of sum, so the subtraction cannot underflow.
        ring_q[wp_q] <= data;
        sum_q        <= sum_q + SW'(data) - SW'(ring_q[wp_q]);
        wp_q         <= (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + PW'(1);
        if (fill_q != FW'(DEPTH)) fill_q <= fill_q + FW'(1);
        full <= full | (fill_q == FW'(DEPTH - 1));
      end
    end
  end

endmodule

// File: rtl/moving_average_mc.sv
// Multi-channel moving-average filter: NCH independent avg_chan instances
// sharing clk, rst and clr_i. Optional build macro AVG_ROUND_EN selects
// round-half-up averaging (latency unchanged).
// Ports:
//   clk, rst   clock, async active-high reset
//   clr_i      synchronous clear of all windows
//   data_i     channel c sample at [c*DW +: DW]
//   en_i       per-channel strobe (rising edge captures)
//   en_o       en_i delayed one clk
//   avg_o      per-channel average lanes
//   vld_o      per-channel one-cycle update pulse
//   full_o     per-channel window-full flag
module moving_average_mc
  import avg_pkg::*;
#(
  parameter int unsigned NCH   = NCH_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic [NCH*DW-1:0] data_i,
  input  logic [NCH-1:0]    en_i,
  output logic [NCH-1:0]    en_o,
  output logic [NCH*DW-1:0] avg_o,
  output logic [NCH-1:0]    vld_o,
  output logic [NCH-1:0]    full_o
);

  for (genvar c = 0; c < int'(NCH); c++) begin : g_chan
    avg_chan #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_i),
      .data (data_i[c*DW +: DW]),
      .en   (en_i[c]),
      .en_d (en_o[c]),
      .avg  (avg_o[c*DW +: DW]),
      .vld  (vld_o[c]),
      .full (full_o[c])
    );
  end

endmodule

// File: tb/tb_moving_average_mc.sv
// Self-checking bench for moving_average_mc with a window-queue reference model.
module tb_moving_average_mc;

  localparam int unsigned NCH   = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr_i;
  logic [NCH*DW-1:0] data_i;
  logic [NCH-1:0]    en_i;
  logic [NCH-1:0]    en_o;
  logic [NCH*DW-1:0] avg_o;
  logic [NCH-1:0]    vld_o;
  logic [NCH-1:0]    full_o;

  int errs   = 0;
  int checks = 0;

  // Reference model: last DEPTH samples per channel plus the expected held average.
  int unsigned win [NCH][$];
  int unsigned exp_avg [NCH];

  moving_average_mc #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr_i),
    .data_i (data_i),
    .en_i   (en_i),
    .en_o   (en_o),
    .avg_o  (avg_o),
    .vld_o  (vld_o),
    .full_o (full_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned model_avg(input int c);
    longint unsigned s;
    s = 0;
    for (int i = 0; i < win[c].size(); i++) s += win[c][i];
`ifdef AVG_ROUND_EN
    s += DEPTH / 2;
`endif
    return int'(s / DEPTH);
  endfunction

  function automatic logic [NCH-1:0] model_full();
    logic [NCH-1:0] f;
    for (int c = 0; c < NCH; c++) f[c] = (win[c].size() == DEPTH);
    return f;
  endfunction

  task automatic model_capture(input logic [NCH-1:0] mask, input logic [NCH*DW-1:0] d);
    for (int c = 0; c < NCH; c++) if (mask[c]) begin
      win[c].push_back(int'(d[c*DW +: DW]));
      if (win[c].size() > DEPTH) void'(win[c].pop_front());
      exp_avg[c] = model_avg(c);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) win[c].delete();
  endtask

  task automatic check_lanes(input string tag);
    for (int c = 0; c < NCH; c++)
      check(tag, 64'(avg_o[c*DW +: DW]), 64'(exp_avg[c]));
    check({tag, "_full"}, 64'(full_o), 64'(model_full()));
  endtask

  // Pulse en for two clocks, hold data through the output edge, check timing and value.
  task automatic strobe(input logic [NCH-1:0] mask, input logic [NCH*DW-1:0] d);
    @(negedge clk);
    data_i = d;
    en_i   = mask;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      if (e == 1) check("en_o", 64'(en_o), 64'(mask));
      if (e == 2) en_i = '0;
      if (e < 4) check("vld_early", 64'(vld_o), 64'(0));
    end
    model_capture(mask, d);
    check("vld", 64'(vld_o), 64'(mask));
    check_lanes("avg");
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    model_clear();
    check("clr_full", 64'(full_o), 64'(0));
    check_lanes("clr_hold");
  endtask

  initial begin
    int cnt;
    logic [NCH*DW-1:0] d;
    rst    = 1'b1;
    clr_i  = 1'b0;
    en_i   = '0;
    data_i = '0;
    for (int c = 0; c < NCH; c++) exp_avg[c] = 0;
    #12;
    check("rst_avg", 64'(avg_o), 64'(0));
    check("rst_vld", 64'(vld_o), 64'(0));
    check("rst_full", 64'(full_o), 64'(0));
    check("rst_en_o", 64'(en_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Ramp on ch0, including one wrap of the ring.
    for (int k = 1; k <= 7; k++) strobe(4'b0001, {48'd0, DW'(6 * k)});

    // All channels at once, distinct constants.
    do_clear();
    for (int k = 0; k < 6; k++) strobe(4'hF, {16'd400, 16'd300, 16'd200, 16'd100});

    // Full scale, then one zero.
    do_clear();
    for (int k = 0; k < 6; k++) strobe(4'b0001, {48'd0, 16'hFFFF});
    strobe(4'b0001, '0);
    check("fs_drop", 64'(avg_o[DW-1:0]), 64'h0000_0000_0000_D554);

    // Small values: truncation vs rounding.
    do_clear();
    for (int k = 0; k < 4; k++) strobe(4'b0001, {48'd0, 16'd1});

    // en held high: exactly one capture.
    do_clear();
    @(negedge clk);
    data_i = {48'd0, 16'd500};
    en_i   = 4'b0001;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (vld_o[0]) cnt++;
    end
    en_i = '0;
    model_capture(4'b0001, {48'd0, 16'd500});
    check("hold_pulses", 64'(cnt), 64'(1));
    check_lanes("hold_avg");

    // clr on the capture edge: sample dropped, no output.
    @(negedge clk);
    data_i = {48'd0, 16'd900};
    en_i   = 4'b0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    en_i  = '0;
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    model_clear();
    check("clrcap_full", 64'(full_o), 64'(0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("clrcap_vld", 64'(vld_o), 64'(0));
    end
    check_lanes("clrcap_hold");
    strobe(4'b0001, {48'd0, 16'd60});

    // clr coincident with the pending update: update suppressed.
    @(negedge clk);
    data_i = {48'd0, 16'd6000};
    en_i   = 4'b0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    en_i = '0;
    @(posedge clk); #1;
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    model_clear();
    check("clrpend_vld", 64'(vld_o), 64'(0));
    check_lanes("clrpend_hold");

    // Async reset mid-window.
    for (int k = 0; k < 3; k++) strobe(4'b0001, {48'd0, DW'($urandom)});
    #3;
    rst = 1'b1;
    #1;
    check("arst_avg", 64'(avg_o), 64'(0));
    check("arst_vld", 64'(vld_o), 64'(0));
    check("arst_full", 64'(full_o), 64'(0));
    check("arst_en_o", 64'(en_o), 64'(0));
    model_clear();
    for (int c = 0; c < NCH; c++) exp_avg[c] = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) strobe(4'b0001, {48'd0, 16'd60});

    // Random masks and data with occasional clears.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) do_clear();
      for (int c = 0; c < NCH; c++) d[c*DW +: DW] = DW'($urandom);
      strobe(NCH'($urandom_range(1, 15)), d);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
